// File: rtl/regfile_wb_pkg.sv
// Shared types and sizing for the integer register file and its pending-write scoreboard.
package regfile_wb_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int PEND_W = 2;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [PEND_W-1:0] pend_cnt_t;

  // x0 is hardwired to zero and never tracked as a writeback target.
  function automatic logic isZeroReg(input reg_idx_t r);
    return (r == reg_idx_t'(0));
  endfunction

endpackage

// File: rtl/regfile_wb_scoreboard.sv
// Per-register pending-write counters: bumped at issue, retired at writeback commit,
// producing busy flags for the read ports, an issue stall, and a sticky underflow error.
module pend_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int NREG   = regfile_wb_pkg::NREG,
  parameter int PEND_W = regfile_wb_pkg::PEND_W
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     wbCommit,
  input  reg_idx_t wbDst,
  input  logic     issueValid,
  input  logic     issueRegwrite,
  input  reg_idx_t issueDst,
  input  logic     flush,
  input  reg_idx_t ra1,
  input  reg_idx_t ra2,
  output logic     busy1,
  output logic     busy2,
  output logic     issueStall,
  output logic     underflowErr
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt [NREG];
  logic              issueReq;
  logic              issueInc;

  assign issueReq   = issueValid & issueRegwrite & ~isZeroReg(issueDst);
  // A commit to the same register frees a slot in this cycle, so issue may proceed.
  assign issueStall = issueReq & (cnt[issueDst] == CNT_MAX) & ~(wbCommit & (wbDst == issueDst));
  assign issueInc   = issueReq & ~issueStall;

  // Busy reflects the post-commit view: a retiring last write is already visible via bypass.
  assign busy1 = ~isZeroReg(ra1) & (cnt[ra1] != '0) &
                 ~(wbCommit & (wbDst == ra1) & (cnt[ra1] == CNT_ONE));
  assign busy2 = ~isZeroReg(ra2) & (cnt[ra2] != '0) &
                 ~(wbCommit & (wbDst == ra2) & (cnt[ra2] == CNT_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        logic incI;
        logic decI;
        incI = issueInc & (issueDst == reg_idx_t'(i));
        decI = wbCommit & (wbDst == reg_idx_t'(i)) & (cnt[i] != '0);
        if (flush)              cnt[i] <= '0;
        else if (incI && !decI) cnt[i] <= cnt[i] + CNT_ONE;
        else if (decI && !incI) cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       underflowErr <= 1'b0;
    else if (!flush && wbCommit && cnt[wbDst] == '0) underflowErr <= 1'b1;
  end

endmodule

// File: rtl/regfile_wb.sv
// Architectural integer register file at the writeback boundary: commits writeback
// records, serves two bypassed read ports, and tracks outstanding writes for hazards.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int XLEN   = regfile_wb_pkg::XLEN,
  parameter int NREG   = regfile_wb_pkg::NREG,
  parameter int PEND_W = regfile_wb_pkg::PEND_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_regwrite,
  input  reg_idx_t        wb_dst,
  input  logic [XLEN-1:0] wb_data,
  input  reg_idx_t        ra1,
  input  reg_idx_t        ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_valid,
  input  logic            issue_regwrite,
  input  reg_idx_t        issue_dst,
  output logic            issue_stall,
  input  logic            flush,
  output logic            underflow_err
);

  logic [XLEN-1:0] regs [NREG];
  logic            wbCommit;

  assign wbCommit = wb_valid & wb_regwrite & ~isZeroReg(wb_dst);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wbCommit) begin
      regs[wb_dst] <= wb_data;
    end
  end

  // Write-first bypass: a same-cycle commit is visible to decode immediately.
  assign rd1 = isZeroReg(ra1)                  ? '0      :
               (wbCommit && (wb_dst == ra1))   ? wb_data : regs[ra1];
  assign rd2 = isZeroReg(ra2)                  ? '0      :
               (wbCommit && (wb_dst == ra2))   ? wb_data : regs[ra2];

  pend_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) uScoreboard (
    .clk           (clk),
    .reset         (reset),
    .wbCommit      (wbCommit),
    .wbDst         (wb_dst),
    .issueValid    (issue_valid),
    .issueRegwrite (issue_regwrite),
    .issueDst      (issue_dst),
    .flush         (flush),
    .ra1           (ra1),
    .ra2           (ra2),
    .busy1         (busy1),
    .busy2         (busy2),
    .issueStall    (issue_stall),
    .underflowErr  (underflow_err)
  );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed and randomized checks of regfile_wb against a behavioural register/scoreboard model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_regwrite;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;
  logic [4:0]  ra1, ra2;
  logic [63:0] rd1, rd2;
  logic        busy1, busy2;
  logic        issue_valid, issue_regwrite;
  logic [4:0]  issue_dst;
  logic        issue_stall;
  logic        flush;
  logic        underflow_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] mRegs [32];
  int          mCnt  [32];
  bit          mErr;

  regfile_wb dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_dst(issue_dst),
    .issue_stall(issue_stall), .flush(flush), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = '0;
      mCnt[i]  = 0;
    end
    mErr = 1'b0;
  endtask

  function automatic bit mCommit();
    return wb_valid && wb_regwrite && (wb_dst != 0);
  endfunction

  function automatic logic [63:0] expRd(input logic [4:0] ra);
    if (ra == 0) return '0;
    if (mCommit() && wb_dst == ra) return wb_data;
    return mRegs[ra];
  endfunction

  function automatic bit expBusy(input logic [4:0] ra);
    if (ra == 0 || mCnt[ra] == 0) return 1'b0;
    return !(mCommit() && wb_dst == ra && mCnt[ra] == 1);
  endfunction

  function automatic bit expStall();
    return issue_valid && issue_regwrite && issue_dst != 0 && mCnt[issue_dst] == 3 &&
           !(mCommit() && wb_dst == issue_dst);
  endfunction

  task automatic drive(input bit wv, input bit wr, input int wd, input logic [63:0] wdat,
                       input int a1, input int a2, input bit iv, input bit ir, input int id,
                       input bit fl);
    wb_valid = wv; wb_regwrite = wr; wb_dst = 5'(wd); wb_data = wdat;
    ra1 = 5'(a1); ra2 = 5'(a2);
    issue_valid = iv; issue_regwrite = ir; issue_dst = 5'(id); flush = fl;
    #2;
  endtask

  task automatic idle(input int a1, input int a2);
    drive(0, 0, 0, '0, a1, a2, 0, 0, 0, 0);
  endtask

  task automatic checkModel(input string tag);
    check({tag, ".rd1"},   rd1,           expRd(ra1));
    check({tag, ".rd2"},   rd2,           expRd(ra2));
    check({tag, ".busy1"}, busy1,         expBusy(ra1));
    check({tag, ".busy2"}, busy2,         expBusy(ra2));
    check({tag, ".stall"}, issue_stall,   expStall());
    check({tag, ".err"},   underflow_err, mErr);
  endtask

  // Advance one edge and apply the same update to the model.
  task automatic tick();
    bit commit, inc;
    int d, oldD;
    commit = mCommit();
    inc    = issue_valid && issue_regwrite && issue_dst != 0 && !expStall();
    d      = int'(wb_dst);
    oldD   = mCnt[d];
    @(posedge clk);
    if (commit) mRegs[d] = wb_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) mCnt[i] = 0;
    end else begin
      if (inc) mCnt[issue_dst] = mCnt[issue_dst] + 1;
      if (commit) begin
        if (oldD == 0) mErr = 1'b1;
        else mCnt[d] = mCnt[d] - 1;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    modelReset();
    idle(5, 7);
    repeat (2) @(posedge clk);
    #1;
    check("reset.rd1", rd1, 64'h0);
    check("reset.busy1", busy1, 1'b0);
    check("reset.stall", issue_stall, 1'b0);
    check("reset.err", underflow_err, 1'b0);
    reset = 1'b0;

    // Bypass of a fresh commit, then the stored value on the next cycle.
    drive(0, 0, 0, '0, 0, 0, 1, 1, 5, 0); checkModel("iss5"); tick();
    drive(1, 1, 5, 64'hDEAD_BEEF_0000_0001, 5, 0, 0, 0, 0, 0);
    checkModel("byp5");
    check("byp5.rd1", rd1, 64'hDEAD_BEEF_0000_0001);
    tick();
    idle(5, 0);
    check("hold5.rd1", rd1, 64'hDEAD_BEEF_0000_0001);
    checkModel("hold5"); tick();

    // Writes to x0 are ignored.
    drive(1, 1, 0, 64'h1234, 0, 0, 0, 0, 0, 0);
    check("x0.rd1", rd1, 64'h0);
    check("x0.busy1", busy1, 1'b0);
    check("x0.err", underflow_err, 1'b0);
    tick();
    idle(0, 0);
    check("x0after.rd1", rd1, 64'h0);
    check("x0after.err", underflow_err, 1'b0);

    // Saturating the counter of x7, then a concurrent commit releasing the stall.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, '0, 0, 7, 1, 1, 7, 0);
      check("sat7.nostall", issue_stall, 1'b0);
      tick();
    end
    drive(0, 0, 0, '0, 0, 7, 1, 1, 7, 0);
    check("sat7.stall", issue_stall, 1'b1);
    check("sat7.busy2", busy2, 1'b1);
    tick();
    drive(1, 1, 7, 64'h77, 0, 7, 1, 1, 7, 0);
    check("sat7.commit.stall", issue_stall, 1'b0);
    checkModel("sat7c"); tick();
    drive(0, 0, 0, '0, 0, 7, 1, 1, 7, 0);
    check("sat7.still3", issue_stall, 1'b1);
    tick();

    // Busy drops in the cycle the only pending write commits.
    drive(0, 0, 0, '0, 0, 0, 1, 1, 9, 0); tick();
    idle(0, 9);
    check("busy9.pre", busy2, 1'b1);
    tick();
    drive(1, 1, 9, 64'h99, 0, 9, 0, 0, 0, 0);
    check("busy9.commit", busy2, 1'b0);
    check("busy9.rd2", rd2, 64'h99);
    tick();

    // Flush clears counters but keeps the concurrent register write.
    drive(0, 0, 0, '0, 0, 0, 1, 1, 3, 0); tick();
    drive(0, 0, 0, '0, 0, 0, 1, 1, 4, 0); tick();
    drive(1, 1, 3, 64'h3333, 0, 0, 0, 0, 0, 1);
    checkModel("flush"); tick();
    idle(3, 4);
    check("flush.rd1", rd1, 64'h3333);
    check("flush.busy1", busy1, 1'b0);
    check("flush.busy2", busy2, 1'b0);
    check("flush.err", underflow_err, 1'b0);
    tick();
    drive(1, 1, 4, 64'h4444, 0, 0, 0, 0, 0, 0); tick();
    idle(0, 0);
    check("under.err", underflow_err, 1'b1);
    tick(); tick();
    idle(0, 0);
    check("under.sticky", underflow_err, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, '0, 0, 0, 1, 1, 7, 0); tick();
    end
    drive(0, 0, 0, '0, 3, 7, 1, 1, 7, 0);
    check("pre.stall", issue_stall, 1'b1);
    check("pre.busy2", busy2, 1'b1);
    check("pre.rd1", rd1, 64'h3333);
    #1;
    reset = 1'b1;
    #1;
    check("arst.rd1", rd1, 64'h0);
    check("arst.rd2", rd2, 64'h0);
    check("arst.busy2", busy2, 1'b0);
    check("arst.stall", issue_stall, 1'b0);
    check("arst.err", underflow_err, 1'b0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic against the model, on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            {$urandom, $urandom}, $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            1'($urandom_range(0, 29) == 0));
      checkModel("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural integer register file: the consuming end of the writeback-stage interface.
- Accepts the per-cycle writeback record (valid, regwrite control, dst, writedata) and commits it to a 32 x XLEN array.
- Serves two combinational read ports to decode, with same-cycle write-to-read bypass.
- Keeps a per-register pending-write scoreboard, incremented at issue and decremented at writeback commit, which drives busy/stall signals for hazard control.

Parameters:
- XLEN, 64, data width.
- NREG, 32, number of architectural registers; index width is $clog2(NREG)=5.
- PEND_W, 2, width of each pending-write counter; maximum count is 2**PEND_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  writeback record valid.
- wb_regwrite  in  1  regwrite bit from the writeback record's ctl.
- wb_dst  in  5  writeback destination register.
- wb_data  in  XLEN  writeback data.
- ra1, ra2  in  5  read addresses.
- rd1, rd2  out  XLEN  read data.
- busy1, busy2  out  1  a write to ra1/ra2 is still outstanding.
- issue_valid  in  1  an instruction issues this cycle.
- issue_regwrite  in  1  the issuing instruction writes a register.
- issue_dst  in  5  destination of the issuing instruction.
- issue_stall  out  1  issue blocked because the counter is saturated.
- flush  in  1  pipeline flush; clears the scoreboard.
- underflow_err  out  1  sticky: a commit arrived with no pending write.

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - all registers 0, all counters 0, underflow_err 0.
  - Resulting outputs: rd1/rd2 = 0 (unless bypassed), busy 0, issue_stall 0.
- Commit: wb_commit = wb_valid & wb_regwrite & (wb_dst != 0).
  - On posedge clk with wb_commit, regs[wb_dst] <= wb_data.
  - Writes to x0 are ignored; x0 always reads 0.
- Read (combinational, zero latency):
  - rdN = 0 if raN == 0;
  - else wb_data if wb_commit & (wb_dst == raN) (write-first bypass);
  - else regs[raN].
- Issue increment: inc = issue_valid & issue_regwrite & (issue_dst != 0) & ~issue_stall.
- issue_stall = issue_valid & issue_regwrite & (issue_dst != 0) & (cnt[issue_dst] == max) & ~(wb_commit & wb_dst == issue_dst).
  - A same-cycle commit to that register frees a slot, so issue proceeds.
- Decrement: dec = wb_commit.
  - If cnt[wb_dst] == 0, the counter is held and underflow_err is set; it stays set until reset.
- Same register, inc and dec in one cycle: counter unchanged.
- Different registers: both updates apply independently.
- busyN = (raN != 0) & (cnt[raN] != 0) & ~(wb_commit & wb_dst == raN & cnt[raN] == 1).
  - This is the post-commit view: the bypassed value is final, so the register is not busy.
- flush (synchronous):
  - All counters <= 0 at the next edge, overriding issue and commit counting in that cycle.
  - The register write of a concurrent commit still occurs.
  - No underflow check in a flush cycle.
  - Commits arriving after a flush, to registers with zero pending, set underflow_err. Flush is only legal once the pipeline has drained those commits.
- No internal latency beyond one edge for state updates. No handshake back to writeback: commits always accept.

Decomposition:
- Shared package pipes (existing): add reg_idx_t (logic [4:0]) and pend_cnt_t. XLEN and NREG come from common.
- The parent unpacks the writeback record fields onto the wb_* ports.
- One natural sub-module: pend_scoreboard (counters, issue_stall, busy, underflow_err). The array and bypass stay in regfile_wb.

Test Plan:
- Reset, then commit dst=5, data=0xDEAD_BEEF_0000_0001, with ra1=5 in the same cycle → rd1 bypasses the value; next cycle, with no commit, rd1 holds the same value.
- Commit dst=0, data=0x1234 with ra1=0 → rd1=0 in that cycle and after; busy1=0; underflow_err stays 0.
- Issue dst=7 three times (PEND_W=2), then a fourth → cnt=3 and issue_stall=1 on the fourth. Repeat with a concurrent commit to 7 → stall=0 and cnt remains 3.
- Issue dst=9 once; next cycle commit dst=9 with ra2=9 → busy2=0 in the commit cycle; previous cycle busy2=1.
- Issue dst=3 and dst=4 (cnt 1 each), then flush concurrent with a commit to 3 → regs[3] written, all counters 0. A later commit to 4 sets underflow_err=1, held until reset.
- Assert reset mid-sequence with counters non-zero and regs written → immediately rd1=rd2=0, busy 0, issue_stall 0, err 0, without waiting for a clock edge.
